controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Moore FSM that sequences the multicycle MIPS datapath (PC, IR, A/B, MDR, AluOut, register bank, memory, ALU muxes).
- Decodes OPCODE/funct from the instruction register and drives every write enable and mux select, one state per datapath step.
- Replaces the stub control unit. Supported instructions: R-type, lw, sw, beq, bne, j, addi.

Parameters:
- None. The state encoding is fixed and exported on Estado.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- OPCODE  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- Overflow  in  1  ALU overflow, combinational
- EscreveMem  out  1  memory write
- EscrevePC  out  1  unconditional PC load
- EscrevePCCond  out  1  conditional PC load (branch)
- InverteZero  out  1  1 = bne, so the PC circuit uses ~zero
- OrigPC  out  2  00 ALU, 01 AluOut, 10 jump target {PC[31:28],IR[25:0],00}, 11 exception vector 0x000000FC
- RegDst  out  1  0 rt, 1 rd
- EscreveReg  out  1  register bank write
- MemparaReg  out  1  0 AluOut, 1 MDR
- IouD  out  1  0 PC, 1 AluOut
- EscreveIR  out  1  IR load
- EscreveMDR  out  1  MDR load
- EscreveAluOut  out  1  AluOut load
- EscreveEPC  out  1  EPC load (exception feature)
- OrigAALU  out  1  0 PC, 1 A
- OrigBALU  out  2  00 B, 01 const 4, 10 signext, 11 signext<<2
- OpALU  out  3  000 add, 001 sub, 010 decode funct
- Estado  out  6  current state code

Behaviour:
- Outputs are decoded combinationally from the registered state only; there is no input-to-output path.
- Any output not listed for a state is 0.
- Any state with reset=1 goes to RESET on the next edge, which aborts the current instruction. RESET drives all outputs 0, so no partial memory or register write occurs.
- Memory read latency is one cycle: the address is presented in state N and data is valid in state N+1.
- States, as code: outputs -> next:
  - 0 RESET: none -> FETCH when reset=0.
  - 1 FETCH: IouD=0 -> FETCH_WAIT.
  - 2 FETCH_WAIT: IouD=0, EscreveIR=1, OrigAALU=0, OrigBALU=01, OpALU=000, EscrevePC=1, OrigPC=00 -> DECODE.
  - 3 DECODE: OrigAALU=0, OrigBALU=11, OpALU=000, EscreveAluOut=1 (branch target). Next state by OPCODE:
    - 0x23, 0x2B -> MEM_ADDR
    - 0x00 -> R_EXEC
    - 0x04, 0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDI_EXEC
    - any other -> FETCH (executes as a nop)
  - 4 MEM_ADDR: OrigAALU=1, OrigBALU=10, OpALU=000, EscreveAluOut=1 -> LW_READ if OPCODE=0x23, else SW_WRITE.
  - 5 LW_READ: IouD=1 -> LW_WAIT.
  - 6 LW_WAIT: IouD=1, EscreveMDR=1 -> LW_WB.
  - 7 LW_WB: RegDst=0, MemparaReg=1, EscreveReg=1 -> FETCH.
  - 8 SW_WRITE: IouD=1, EscreveMem=1 -> FETCH.
  - 9 R_EXEC: OrigAALU=1, OrigBALU=00, OpALU=010, EscreveAluOut=1 -> R_WB (see Optional Feature).
  - 10 R_WB: RegDst=1, MemparaReg=0, EscreveReg=1 -> FETCH.
  - 11 BRANCH: OrigAALU=1, OrigBALU=00, OpALU=001, EscrevePCCond=1, OrigPC=01, InverteZero=(OPCODE==0x05) -> FETCH.
  - 12 JUMP: EscrevePC=1, OrigPC=10 -> FETCH.
  - 13 ADDI_EXEC: OrigAALU=1, OrigBALU=10, OpALU=000, EscreveAluOut=1 -> ADDI_WB.
  - 14 ADDI_WB: RegDst=0, MemparaReg=0, EscreveReg=1 -> FETCH.
  - 15 OVF_EXC: EscreveEPC=1, EscrevePC=1, OrigPC=11 -> FETCH.
- Instruction cycle counts: lw 7, sw 5, R-type 5, addi 5, beq/bne 4, j 4, unknown opcode 3.
- OPCODE and funct are sampled only in DECODE, MEM_ADDR, R_EXEC and BRANCH; IR is stable there because EscreveIR=0.
- Unused state codes (16–63) -> RESET-equivalent outputs, then FETCH.

Optional Feature:
- Macro: CONTROLE_OVERFLOW_EN.
- Defined:
  - R_EXEC with Overflow=1 and funct in {0x20 add, 0x22 sub} -> OVF_EXC instead of R_WB.
  - ADDI_EXEC with Overflow=1 -> OVF_EXC instead of ADDI_WB.
  - In both cases the destination register is not written.
- Undefined:
  - Overflow is ignored.
  - EscreveEPC is held at 0.
  - State 15 is unreachable.
  - Port list is unchanged.

Test Plan:
- Reset held for 3 cycles during LW_WAIT, then released -> Estado=0 with all enables 0 while reset is high. Estado=1 on the first cycle after release, then 2. No EscreveReg pulse occurs.
- lw (0x23): Estado sequence 1,2,3,4,5,6,7,1. EscreveMDR=1 only in state 6. EscreveReg=1 with MemparaReg=1 only in state 7.
- sw (0x2B): sequence 1,2,3,4,8,1. EscreveMem=1 with IouD=1 only in state 8.
- add (0x00/0x20) then bne (0x05): R sequence 1,2,3,9,10,1 with RegDst=1 in state 10. bne sequence 1,2,3,11,1 with InverteZero=1, EscrevePCCond=1, OrigPC=01.
- j (0x02) then opcode 0x3F: j gives 1,2,3,12,1 with OrigPC=10, EscrevePC=1. Opcode 0x3F gives 1,2,3,1 with no writes after state 2.
- With CONTROLE_OVERFLOW_EN, addi and Overflow=1 in state 13 -> state 15 with EscreveEPC=1, OrigPC=11, then 1, and no EscreveReg. Without the macro -> state 14 with EscreveReg=1.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Moore control FSM for the multicycle MIPS datapath.
// Define CONTROLE_OVERFLOW_EN to trap add/sub/addi overflow into OVF_EXC.
module controle_multiciclo (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] funct,
    input  logic       Overflow,
    output logic       EscreveMem,
    output logic       EscrevePC,
    output logic       EscrevePCCond,
    output logic       InverteZero,
    output logic [1:0] OrigPC,
    output logic       RegDst,
    output logic       EscreveReg,
    output logic       MemparaReg,
    output logic       IouD,
    output logic       EscreveIR,
    output logic       EscreveMDR,
    output logic       EscreveAluOut,
    output logic       EscreveEPC,
    output logic       OrigAALU,
    output logic [1:0] OrigBALU,
    output logic [2:0] OpALU,
    output logic [5:0] Estado
);

    typedef enum logic [5:0] {
        S_RESET      = 6'd0,
        S_FETCH      = 6'd1,
        S_FETCH_WAIT = 6'd2,
        S_DECODE     = 6'd3,
        S_MEM_ADDR   = 6'd4,
        S_LW_READ    = 6'd5,
        S_LW_WAIT    = 6'd6,
        S_LW_WB      = 6'd7,
        S_SW_WRITE   = 6'd8,
        S_R_EXEC     = 6'd9,
        S_R_WB       = 6'd10,
        S_BRANCH     = 6'd11,
        S_JUMP       = 6'd12,
        S_ADDI_EXEC  = 6'd13,
        S_ADDI_WB    = 6'd14,
        S_OVF_EXC    = 6'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t state;
    state_t next_state;

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_RESET;
        else
            state <= next_state;
    end

`ifndef CONTROLE_OVERFLOW_EN
    logic unused_ovf;
    assign unused_ovf = ^{Overflow, funct};
`endif

    always_comb begin
        next_state    = S_FETCH;
        EscreveMem    = 1'b0;
        EscrevePC     = 1'b0;
        EscrevePCCond = 1'b0;
        InverteZero   = 1'b0;
        OrigPC        = 2'b00;
        RegDst        = 1'b0;
        EscreveReg    = 1'b0;
        MemparaReg    = 1'b0;
        IouD          = 1'b0;
        EscreveIR     = 1'b0;
        EscreveMDR    = 1'b0;
        EscreveAluOut = 1'b0;
        EscreveEPC    = 1'b0;
        OrigAALU      = 1'b0;
        OrigBALU      = 2'b00;
        OpALU         = 3'b000;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: next_state = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                EscreveIR  = 1'b1;
                OrigBALU   = 2'b01;
                EscrevePC  = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed speculatively while decoding
                OrigBALU      = 2'b11;
                EscreveAluOut = 1'b1;
                case (OPCODE)
                    OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                    OP_R:           next_state = S_R_EXEC;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    OP_ADDI:        next_state = S_ADDI_EXEC;
                    default:        next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                OrigAALU      = 1'b1;
                OrigBALU      = 2'b10;
                EscreveAluOut = 1'b1;
                next_state    = (OPCODE == OP_LW) ? S_LW_READ : S_SW_WRITE;
            end
            S_LW_READ: begin
                IouD       = 1'b1;
                next_state = S_LW_WAIT;
            end
            S_LW_WAIT: begin
                IouD       = 1'b1;
                EscreveMDR = 1'b1;
                next_state = S_LW_WB;
            end
            S_LW_WB: begin
                MemparaReg = 1'b1;
                EscreveReg = 1'b1;
            end
            S_SW_WRITE: begin
                IouD       = 1'b1;
                EscreveMem = 1'b1;
            end
            S_R_EXEC: begin
                OrigAALU      = 1'b1;
                OpALU         = 3'b010;
                EscreveAluOut = 1'b1;
                next_state    = S_R_WB;
`ifdef CONTROLE_OVERFLOW_EN
                if (Overflow && (funct == 6'h20 || funct == 6'h22))
                    next_state = S_OVF_EXC;
`endif
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                EscreveReg = 1'b1;
            end
            S_BRANCH: begin
                OrigAALU      = 1'b1;
                OpALU         = 3'b001;
                EscrevePCCond = 1'b1;
                OrigPC        = 2'b01;
                InverteZero   = (OPCODE == OP_BNE);
            end
            S_JUMP: begin
                EscrevePC = 1'b1;
                OrigPC    = 2'b10;
            end
            S_ADDI_EXEC: begin
                OrigAALU      = 1'b1;
                OrigBALU      = 2'b10;
                EscreveAluOut = 1'b1;
                next_state    = S_ADDI_WB;
`ifdef CONTROLE_OVERFLOW_EN
                if (Overflow)
                    next_state = S_OVF_EXC;
`endif
            end
            S_ADDI_WB: EscreveReg = 1'b1;
            S_OVF_EXC: begin
`ifdef CONTROLE_OVERFLOW_EN
                EscreveEPC = 1'b1;
`endif
                EscrevePC  = 1'b1;
                OrigPC     = 2'b11;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign Estado = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: per-cycle expected
// state code and output vector are queued, then popped at negedge.
module tb_controle_multiciclo;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] OPCODE;
    logic [5:0] funct;
    logic       Overflow;
    logic       EscreveMem, EscrevePC, EscrevePCCond, InverteZero;
    logic [1:0] OrigPC;
    logic       RegDst, EscreveReg, MemparaReg, IouD, EscreveIR;
    logic       EscreveMDR, EscreveAluOut, EscreveEPC, OrigAALU;
    logic [1:0] OrigBALU;
    logic [2:0] OpALU;
    logic [5:0] Estado;

    int n_tests = 0;
    int n_fail  = 0;
    logic [25:0] sb[$];
    logic [25:0] exp_v;
    logic [25:0] obs;

    always #5 clock = ~clock;

    controle_multiciclo dut (
        .clock(clock), .reset(reset), .OPCODE(OPCODE), .funct(funct),
        .Overflow(Overflow), .EscreveMem(EscreveMem),
        .EscrevePC(EscrevePC), .EscrevePCCond(EscrevePCCond),
        .InverteZero(InverteZero), .OrigPC(OrigPC), .RegDst(RegDst),
        .EscreveReg(EscreveReg), .MemparaReg(MemparaReg), .IouD(IouD),
        .EscreveIR(EscreveIR), .EscreveMDR(EscreveMDR),
        .EscreveAluOut(EscreveAluOut), .EscreveEPC(EscreveEPC),
        .OrigAALU(OrigAALU), .OrigBALU(OrigBALU), .OpALU(OpALU),
        .Estado(Estado)
    );

    assign obs = {Estado, EscreveMem, EscrevePC, EscrevePCCond,
                  InverteZero, OrigPC, RegDst, EscreveReg, MemparaReg,
                  IouD, EscreveIR, EscreveMDR, EscreveAluOut, EscreveEPC,
                  OrigAALU, OrigBALU, OpALU};

    // Expected outputs of each state, written straight from the state table
    function automatic logic [25:0] spec_vec(input int st, input logic [5:0] op);
        logic mem, pc, pcc, inv, rdst, wreg, m2r, iod, wir, wmdr, wao, epc, aa;
        logic [1:0] opc, ba;
        logic [2:0] alu;
        {mem, pc, pcc, inv, rdst, wreg, m2r, iod, wir, wmdr, wao, epc, aa} = '0;
        opc = 2'b00; ba = 2'b00; alu = 3'b000;
        case (st)
            2:  begin wir = 1; ba = 2'b01; pc = 1; end
            3:  begin ba = 2'b11; wao = 1; end
            4:  begin aa = 1; ba = 2'b10; wao = 1; end
            5:  iod = 1;
            6:  begin iod = 1; wmdr = 1; end
            7:  begin wreg = 1; m2r = 1; end
            8:  begin iod = 1; mem = 1; end
            9:  begin aa = 1; alu = 3'b010; wao = 1; end
            10: begin rdst = 1; wreg = 1; end
            11: begin aa = 1; alu = 3'b001; pcc = 1; opc = 2'b01;
                      inv = (op == 6'h05); end
            12: begin pc = 1; opc = 2'b10; end
            13: begin aa = 1; ba = 2'b10; wao = 1; end
            14: wreg = 1;
            15: begin epc = 1; pc = 1; opc = 2'b11; end
            default: ;
        endcase
        return {st[5:0], mem, pc, pcc, inv, opc, rdst, wreg, m2r, iod,
                wir, wmdr, wao, epc, aa, ba, alu};
    endfunction

    task automatic push_seq(input int seq[$], input logic [5:0] op);
        foreach (seq[i]) sb.push_back(spec_vec(seq[i], op));
    endtask

    task automatic test_reset();
        reset = 1'b1; OPCODE = 6'h00; funct = 6'h00; Overflow = 1'b0;
        push_seq('{0, 0, 0}, 6'h00);
        repeat (2) @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
        reset = 1'b0;
        push_seq('{0}, 6'h00);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_release: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_lw();
        OPCODE = 6'h23; funct = 6'h00;
        push_seq('{1, 2, 3, 4, 5, 6, 7}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lw: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_sw();
        OPCODE = 6'h2B; funct = 6'h15;
        push_seq('{1, 2, 3, 4, 8}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL sw: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_add_bne();
        OPCODE = 6'h00; funct = 6'h20;
        push_seq('{1, 2, 3, 9, 10}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL add: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
        OPCODE = 6'h05;
        push_seq('{1, 2, 3, 11}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL bne: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
        OPCODE = 6'h04;
        push_seq('{1, 2, 3, 11}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL beq: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_j_nop();
        OPCODE = 6'h02;
        push_seq('{1, 2, 3, 12}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL j: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
        OPCODE = 6'h3F;
        push_seq('{1, 2, 3}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL nop: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_addi_ovf();
        OPCODE = 6'h08; funct = 6'h20; Overflow = 1'b1;
`ifdef CONTROLE_OVERFLOW_EN
        push_seq('{1, 2, 3, 13, 15}, OPCODE);
`else
        push_seq('{1, 2, 3, 13, 14}, OPCODE);
`endif
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL addi_ovf: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
        // R-type sub with Overflow still raised
        OPCODE = 6'h00; funct = 6'h22;
`ifdef CONTROLE_OVERFLOW_EN
        push_seq('{1, 2, 3, 9, 15}, OPCODE);
`else
        push_seq('{1, 2, 3, 9, 10}, OPCODE);
`endif
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL sub_ovf: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
        Overflow = 1'b0;
    endtask

    task automatic test_reset_lw_wait();
        OPCODE = 6'h23; funct = 6'h00;
        push_seq('{1, 2, 3, 4, 5}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lw_pre_reset: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
        reset = 1'b1;
        push_seq('{6, 0, 0}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_abort: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
        reset = 1'b0;
        push_seq('{0, 1, 2, 3, 4, 5, 6, 7}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL after_abort: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        OPCODE = 6'h2B;
        push_seq('{1, 2, 3, 4, 8}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_sw: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
        OPCODE = 6'h08; Overflow = 1'b0;
        push_seq('{1, 2, 3, 13, 14, 1}, OPCODE);
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_addi: got %h, want %h", obs, exp_v);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_add_bne();
        test_j_nop();
        test_addi_ovf();
        test_reset_lw_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
